// File: rtl/snow64_icache_line_fill_responder.sv
// Instruction-cache line-fill responder: fetches one 256-bit line as four 64-bit memory beats.
// Define SNOW64_ICACHE_FILL_CRITICAL_WORD_FIRST_EN to start at the requested beat and wrap.
module snow64_icache_line_fill_responder #(
  parameter int WIDTH__ADDR = 64,
  parameter int WIDTH__LINE = 256,
  parameter int WIDTH__BEAT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_fill_req,
  input  logic [WIDTH__ADDR-1:0] in_fill_addr,
  output logic                   out_fill_valid,
  output logic [WIDTH__LINE-1:0] out_fill_data,
  output logic                   out_busy,
  output logic                   out_mem_req,
  output logic [WIDTH__ADDR-1:0] out_mem_addr,
  input  logic                   in_mem_ack,
  input  logic [WIDTH__BEAT-1:0] in_mem_data
);

  localparam int BEATS      = WIDTH__LINE / WIDTH__BEAT;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam int BEAT_OFF_W = $clog2(WIDTH__BEAT / 8);
  localparam int LINE_OFF_W = BEAT_OFF_W + BEAT_IDX_W;

  typedef enum logic {StIdle, StFetch} state_t;

  state_t                            state_q;
  logic [WIDTH__ADDR-LINE_OFF_W-1:0] base_q;
  logic [BEAT_IDX_W-1:0]             beat_q;
  logic [BEAT_IDX_W-1:0]             remain_q;
  logic                              fill_valid_q;
  logic                              busy_q;
  logic                              mem_req_q;
  logic [WIDTH__ADDR-1:0]            mem_addr_q;
  logic [WIDTH__LINE-1:0]            fill_data_q;
  logic [WIDTH__LINE-1:0]            line_buf_q;

  logic [BEAT_IDX_W-1:0]             start_beat;
  logic [BEAT_IDX_W-1:0]             beat_d;
  logic [WIDTH__LINE-1:0]            line_d;

`ifdef SNOW64_ICACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic unused_addr_bits;
  assign start_beat       = in_fill_addr[LINE_OFF_W-1:BEAT_OFF_W];
  assign unused_addr_bits = ^in_fill_addr[BEAT_OFF_W-1:0];
`else
  logic unused_addr_bits;
  assign start_beat       = '0;
  assign unused_addr_bits = ^in_fill_addr[LINE_OFF_W-1:0];
`endif

  assign beat_d = beat_q + BEAT_IDX_W'(1);

  // Assembly buffer with the current beat merged in; stored in natural beat order.
  always_comb begin
    line_d = line_buf_q;
    line_d[beat_q*WIDTH__BEAT +: WIDTH__BEAT] = in_mem_data;
  end

  // Fully overwritten every fill, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == StFetch && in_mem_ack) begin
      line_buf_q <= line_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      base_q       <= '0;
      beat_q       <= '0;
      remain_q     <= '0;
      fill_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fill_data_q  <= '0;
    end else begin
      fill_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_fill_req) begin
            base_q     <= in_fill_addr[WIDTH__ADDR-1:LINE_OFF_W];
            beat_q     <= start_beat;
            remain_q   <= BEAT_IDX_W'(BEATS - 1);
            busy_q     <= 1'b1;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {in_fill_addr[WIDTH__ADDR-1:LINE_OFF_W], start_beat,
                           {BEAT_OFF_W{1'b0}}};
            state_q    <= StFetch;
          end
        end
        StFetch: begin
          if (in_mem_ack) begin
            if (remain_q == '0) begin
              fill_data_q  <= line_d;
              fill_valid_q <= 1'b1;
              busy_q       <= 1'b0;
              mem_req_q    <= 1'b0;
              state_q      <= StIdle;
            end else begin
              beat_q     <= beat_d;
              remain_q   <= remain_q - BEAT_IDX_W'(1);
              mem_addr_q <= {base_q, beat_d, {BEAT_OFF_W{1'b0}}};
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_fill_valid = fill_valid_q;
  assign out_fill_data  = fill_data_q;
  assign out_busy       = busy_q;
  assign out_mem_req    = mem_req_q;
  assign out_mem_addr   = mem_addr_q;

`ifndef SYNTHESIS
  // Requests arriving mid-fill are dropped; make that visible in simulation.
  always @(posedge clk) begin
    if (rst_n && state_q == StFetch && in_fill_req) begin
      $info("snow64_icache_line_fill_responder: protocol error, fill request 0x%0h ignored while busy",
            in_fill_addr);
    end
  end
`endif

endmodule

// File: tb/tb_snow64_icache_line_fill_responder.sv
// Scoreboard bench for the icache line-fill responder: a memory model answers beats,
// expected lines/addresses/latencies are queued at issue time and checked by monitors.
module tb_snow64_icache_line_fill_responder;

`ifdef SNOW64_ICACHE_FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_fill_req;
  logic [63:0]  in_fill_addr;
  logic         out_fill_valid;
  logic [255:0] out_fill_data;
  logic         out_busy;
  logic         out_mem_req;
  logic [63:0]  out_mem_addr;
  logic         in_mem_ack;
  logic [63:0]  in_mem_data;

  snow64_icache_line_fill_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_fill_req   (in_fill_req),
    .in_fill_addr  (in_fill_addr),
    .out_fill_valid(out_fill_valid),
    .out_fill_data (out_fill_data),
    .out_busy      (out_busy),
    .out_mem_req   (out_mem_req),
    .out_mem_addr  (out_mem_addr),
    .in_mem_ack    (in_mem_ack),
    .in_mem_data   (in_mem_data)
  );

  int           n_checks = 0;
  int           n_pass   = 0;
  longint       cyc      = 0;
  logic [63:0]  mem [logic [63:0]];
  logic [255:0] exp_line_q [$];
  longint       exp_cyc_q  [$];
  logic [63:0]  exp_addr_q [$];
  logic [255:0] last_line  = '0;
  longint       busy_from  = 1;
  longint       busy_to    = 0;
  int           stall_cfg  = 0;
  logic [255:0] mon_line;
  longint       mon_cyc;
  logic         exp_busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  // Caller is at posedge+1; the request is visible during this cycle and sampled at the next edge.
  task automatic start_fill(input logic [63:0] addr, input int s, input logic [255:0] line);
    logic [63:0] base;
    int          st;
    base = addr & ~64'h1F;
    st   = CWF ? int'(addr[4:3]) : 0;
    for (int k = 0; k < 4; k++) mem[base + 64'(8 * k)] = line[k*64 +: 64];
    for (int k = 0; k < 4; k++) exp_addr_q.push_back(base + 64'(8 * ((st + k) % 4)));
    exp_line_q.push_back(line);
    exp_cyc_q.push_back(cyc + 5 + 4 * s);
    busy_from    = cyc + 1;
    busy_to      = cyc + 4 + 4 * s;
    stall_cfg    = s;
    in_fill_req  = 1'b1;
    in_fill_addr = addr;
    @(posedge clk); #1;
    in_fill_req  = 1'b0;
    in_fill_addr = {$urandom(), $urandom()};
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_line_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_line_q.size() != 0) begin
      n_checks++;
      $display("FAIL fill_timeout: %0d fills still outstanding, want 0", exp_line_q.size());
      exp_line_q.delete();
      exp_cyc_q.delete();
      exp_addr_q.delete();
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_fill_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_fill_valid) begin
      n_checks++;
      $display("FAIL valid_timeout: out_fill_valid=0 after %0d cycles, want 1", n);
    end
  endtask

  // Memory model: answers each beat after stall_cfg wait cycles, acks randomly while idle.
  initial begin
    int          beat_wait;
    logic [63:0] held_addr;
    beat_wait   = 0;
    held_addr   = '0;
    in_mem_ack  = 1'b0;
    in_mem_data = '0;
    forever begin
      @(posedge clk); #2;
      in_mem_ack = 1'b0;
      if (!rst_n) begin
        beat_wait = 0;
      end else if (out_mem_req) begin
        if (beat_wait == 0) held_addr = out_mem_addr;
        else check("addr_stable_in_stall", 256'(out_mem_addr), 256'(held_addr));
        if (beat_wait < stall_cfg) begin
          beat_wait++;
        end else begin
          if (exp_addr_q.size() == 0) check("extra_beat_req", 256'(out_mem_req), 256'(1'b0));
          else check("beat_addr", 256'(out_mem_addr), 256'(exp_addr_q.pop_front()));
          in_mem_ack  = 1'b1;
          in_mem_data = mem.exists(out_mem_addr) ? mem[out_mem_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
          beat_wait   = 0;
        end
      end else begin
        beat_wait   = 0;
        in_mem_ack  = 1'($urandom_range(0, 1));
        in_mem_data = {$urandom(), $urandom()};
      end
    end
  end

  // Output monitor: busy window, valid pulses against the scoreboard, data hold between fills.
  always @(negedge clk) begin
    exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
    check("busy", 256'(out_busy), 256'(exp_busy));
    check("mem_req", 256'(out_mem_req), 256'(exp_busy));
    if (out_fill_valid) begin
      if (exp_line_q.size() == 0) begin
        check("spurious_valid", 256'(out_fill_valid), 256'(1'b0));
      end else begin
        mon_line = exp_line_q.pop_front();
        mon_cyc  = exp_cyc_q.pop_front();
        check("fill_data", out_fill_data, mon_line);
        check("fill_latency", 256'(cyc), 256'(mon_cyc));
        last_line = mon_line;
      end
    end else begin
      check("fill_data_hold", out_fill_data, last_line);
    end
  end

  initial begin
    rst_n        = 1'b1;
    in_fill_req  = 1'b0;
    in_fill_addr = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_fill_valid", 256'(out_fill_valid), 256'(1'b0));
    check("rst_fill_data", out_fill_data, 256'(0));
    check("rst_busy", 256'(out_busy), 256'(1'b0));
    check("rst_mem_req", 256'(out_mem_req), 256'(1'b0));
    check("rst_mem_addr", 256'(out_mem_addr), 256'(0));
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;

    @(posedge clk); #1;
    start_fill(64'h1000, 0, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    wait_idle();
    @(posedge clk); #1;
    start_fill(64'h2014, 0, rand_line());
    wait_idle();
    @(posedge clk); #1;
    start_fill({$urandom(), $urandom()}, 2, rand_line());
    wait_idle();

    // Second request mid-fill must be dropped.
    @(posedge clk); #1;
    start_fill(64'h4008, 1, rand_line());
    repeat (2) @(posedge clk);
    #1;
    in_fill_req  = 1'b1;
    in_fill_addr = 64'h3000;
    @(posedge clk); #1;
    in_fill_req  = 1'b0;
    wait_idle();

    // Abort after the second beat's ack; outputs must clear without a clock edge.
    @(posedge clk); #1;
    start_fill(64'h5000, 0, rand_line());
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_mem_req", 256'(out_mem_req), 256'(1'b0));
    check("abort_busy", 256'(out_busy), 256'(1'b0));
    check("abort_fill_valid", 256'(out_fill_valid), 256'(1'b0));
    check("abort_fill_data", out_fill_data, 256'(0));
    void'(exp_line_q.pop_back());
    void'(exp_cyc_q.pop_back());
    exp_addr_q.delete();
    busy_from = 1;
    busy_to   = 0;
    last_line = '0;
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    start_fill(64'h6018, 0, rand_line());
    wait_idle();

    // Random fills, mostly issued in the valid cycle of the previous one.
    @(posedge clk); #1;
    start_fill({$urandom(), $urandom()}, $urandom_range(0, 3), rand_line());
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end else begin
        wait_valid();
      end
      start_fill({$urandom(), $urandom()}, $urandom_range(0, 3), rand_line());
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("fills_all_returned", 256'(exp_line_q.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
